// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between the CPU and a debug/loader
// master. Supports a bounded debug lock and routes read data back to the issuer.
module mem_port_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_LOCK = 8
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [ADDR_W-1:0]     cpu_addr,
    input  logic [DATA_W-1:0]     cpu_wdata,
    input  logic [DATA_W/8-1:0]   cpu_wmask,
    output logic                  cpu_gnt,
    output logic                  cpu_rvalid,
    output logic [DATA_W-1:0]     cpu_rdata,

    input  logic                  dbg_req,
    input  logic                  dbg_we,
    input  logic [ADDR_W-1:0]     dbg_addr,
    input  logic [DATA_W-1:0]     dbg_wdata,
    input  logic [DATA_W/8-1:0]   dbg_wmask,
    input  logic                  dbg_lock,
    output logic                  dbg_gnt,
    output logic                  dbg_rvalid,
    output logic [DATA_W-1:0]     dbg_rdata,

    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic [DATA_W/8-1:0]   mem_wmask,
    input  logic [DATA_W-1:0]     mem_rdata
);

    localparam int CNT_W = $clog2(MAX_LOCK + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_LOCK);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic {OWNER_CPU = 1'b0, OWNER_DBG = 1'b1} owner_e;
    typedef enum logic {UNLOCKED = 1'b0, LOCKED = 1'b1} lock_state_e;

    owner_e            last_gnt_q, last_gnt_d;
    lock_state_e       lock_state_q, lock_state_d;
    logic [CNT_W-1:0]  lock_cnt_q, lock_cnt_d;
    logic              rd_pend_q, rd_pend_d;
    owner_e            rd_owner_q, rd_owner_d;
    logic              lock_hold;

    always_comb begin
        cpu_gnt   = 1'b0;
        dbg_gnt   = 1'b0;
        lock_hold = (lock_state_q == LOCKED) && (lock_cnt_q < CNT_MAX);
        if (!reset) begin
            if (lock_hold) begin
                dbg_gnt = dbg_req;
            end else if (cpu_req && dbg_req) begin
                if (last_gnt_q == OWNER_DBG) cpu_gnt = 1'b1;
                else                         dbg_gnt = 1'b1;
            end else begin
                cpu_gnt = cpu_req;
                dbg_gnt = dbg_req;
            end
        end
    end

    // Idle port presents the CPU's request fields; mem_en stays low.
    assign mem_en    = cpu_gnt | dbg_gnt;
    assign mem_we    = dbg_gnt ? dbg_we    : cpu_we;
    assign mem_addr  = dbg_gnt ? dbg_addr  : cpu_addr;
    assign mem_wdata = dbg_gnt ? dbg_wdata : cpu_wdata;
    assign mem_wmask = mem_we ? (dbg_gnt ? dbg_wmask : cpu_wmask) : '0;

    always_comb begin
        last_gnt_d   = last_gnt_q;
        lock_state_d = lock_state_q;
        lock_cnt_d   = lock_cnt_q;
        rd_pend_d    = mem_en && !mem_we;
        rd_owner_d   = rd_owner_q;

        if (mem_en && !mem_we) begin
            rd_owner_d = dbg_gnt ? OWNER_DBG : OWNER_CPU;
        end

        // Release is evaluated before any relock so a forced release always wins.
        if (lock_state_q == UNLOCKED) begin
            if (dbg_gnt && dbg_lock) begin
                lock_state_d = LOCKED;
                lock_cnt_d   = CNT_ONE;
            end
        end else begin
            if (lock_cnt_q == CNT_MAX) begin
                lock_state_d = UNLOCKED;
                lock_cnt_d   = '0;
                last_gnt_d   = OWNER_DBG;
            end else if (!dbg_lock) begin
                lock_state_d = UNLOCKED;
                lock_cnt_d   = '0;
            end else begin
                lock_cnt_d   = lock_cnt_q + CNT_ONE;
            end
        end

        if (cpu_gnt)      last_gnt_d = OWNER_CPU;
        else if (dbg_gnt) last_gnt_d = OWNER_DBG;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_gnt_q   <= OWNER_DBG;
            lock_state_q <= UNLOCKED;
            lock_cnt_q   <= '0;
            rd_pend_q    <= 1'b0;
            rd_owner_q   <= OWNER_CPU;
        end else begin
            last_gnt_q   <= last_gnt_d;
            lock_state_q <= lock_state_d;
            lock_cnt_q   <= lock_cnt_d;
            rd_pend_q    <= rd_pend_d;
            rd_owner_q   <= rd_owner_d;
        end
    end

    // A read granted just before reset must not surface while reset is high.
    assign cpu_rvalid = !reset && rd_pend_q && (rd_owner_q == OWNER_CPU);
    assign dbg_rvalid = !reset && rd_pend_q && (rd_owner_q == OWNER_DBG);
    assign cpu_rdata  = mem_rdata;
    assign dbg_rdata  = mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed plus randomized bench for mem_port_arbiter against a cycle-level
// reference model with its own copy of a 16-word memory.
module tb_mem_port_arbiter;

    localparam int MAX_LOCK = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req, cpu_we, dbg_req, dbg_we, dbg_lock;
    logic [31:0] cpu_addr, cpu_wdata, dbg_addr, dbg_wdata;
    logic [3:0]  cpu_wmask, dbg_wmask;
    logic        cpu_gnt, dbg_gnt, cpu_rvalid, dbg_rvalid;
    logic [31:0] cpu_rdata, dbg_rdata;
    logic        mem_en, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_rdata;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_LOCK(MAX_LOCK)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_wmask(cpu_wmask), .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_wmask(dbg_wmask), .dbg_lock(dbg_lock), .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid),
        .dbg_rdata(dbg_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wmask(mem_wmask), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [31:0] mem_arr   [16];
    logic [31:0] mem_model [16];

    // Reference model: 0 = nobody, 1 = CPU, 2 = DBG
    int          m_last;
    bit          m_locked;
    int          m_held;
    int          m_rv;
    logic [31:0] m_rdata;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_last   = 2;
        m_locked = 1'b0;
        m_held   = 0;
        m_rv     = 0;
    endtask

    task automatic set_cpu(input bit req, input bit we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] mask);
        cpu_req = req; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata; cpu_wmask = mask;
    endtask

    task automatic set_dbg(input bit req, input bit we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] mask, input bit lock);
        dbg_req = req; dbg_we = we; dbg_addr = addr; dbg_wdata = wdata; dbg_wmask = mask;
        dbg_lock = lock;
    endtask

    // One clock cycle: check outputs against the model, advance model and memory.
    task automatic cycle();
        int          win;
        int          exp_rv;
        bit          e_we;
        logic [31:0] e_addr, e_wdata, e_mask;
        logic [3:0]  raw_mask;
        logic [3:0]  s_idx;
        logic        s_en, s_we;
        logic [31:0] s_wdata;
        logic [3:0]  s_mask;
        #1;
        if (reset)                                      win = 0;
        else if (m_locked && m_held < MAX_LOCK)         win = dbg_req ? 2 : 0;
        else if (cpu_req && dbg_req)                    win = (m_last == 1) ? 2 : 1;
        else if (cpu_req)                               win = 1;
        else if (dbg_req)                               win = 2;
        else                                            win = 0;

        e_we     = (win == 2) ? dbg_we    : cpu_we;
        e_addr   = (win == 2) ? dbg_addr  : cpu_addr;
        e_wdata  = (win == 2) ? dbg_wdata : cpu_wdata;
        raw_mask = (win == 2) ? dbg_wmask : cpu_wmask;
        e_mask   = e_we ? {28'd0, raw_mask} : 32'd0;
        exp_rv   = reset ? 0 : m_rv;

        chk("cpu_gnt",    32'(cpu_gnt),    32'(win == 1));
        chk("dbg_gnt",    32'(dbg_gnt),    32'(win == 2));
        chk("mem_en",     32'(mem_en),     32'(win != 0));
        chk("mem_we",     32'(mem_we),     32'(e_we));
        chk("mem_addr",   mem_addr,        e_addr);
        chk("mem_wdata",  mem_wdata,       e_wdata);
        chk("mem_wmask",  32'(mem_wmask),  e_mask);
        chk("cpu_rvalid", 32'(cpu_rvalid), 32'(exp_rv == 1));
        chk("dbg_rvalid", 32'(dbg_rvalid), 32'(exp_rv == 2));
        if (exp_rv == 1) chk("cpu_rdata", cpu_rdata, m_rdata);
        if (exp_rv == 2) chk("dbg_rdata", dbg_rdata, m_rdata);

        if (win != 0 || exp_rv != 0)
            $display("cyc %0d rst=%0b gnt=%s we=%0b addr=%h rvalid_to=%s",
                     cyc, reset, (win == 1) ? "CPU" : (win == 2) ? "DBG" : "---",
                     e_we, e_addr, (exp_rv == 1) ? "CPU" : (exp_rv == 2) ? "DBG" : "---");

        if (reset) begin
            model_reset();
        end else begin
            m_rv = (win != 0 && !e_we) ? win : 0;
            if (win != 0 && !e_we) m_rdata = mem_model[e_addr[5:2]];
            if (win != 0 && e_we)
                for (int b = 0; b < 4; b++)
                    if (raw_mask[b]) mem_model[e_addr[5:2]][b*8 +: 8] = e_wdata[b*8 +: 8];
            if (m_locked) begin
                if (m_held == MAX_LOCK) begin
                    m_locked = 1'b0; m_held = 0; m_last = 2;
                end else if (!dbg_lock) begin
                    m_locked = 1'b0; m_held = 0;
                end else begin
                    m_held++;
                end
            end else if (win == 2 && dbg_lock) begin
                m_locked = 1'b1; m_held = 1;
            end
            if (win != 0) m_last = win;
        end

        s_en = mem_en; s_we = mem_we; s_idx = mem_addr[5:2];
        s_wdata = mem_wdata; s_mask = mem_wmask;
        @(posedge clk);
        if (s_en) begin
            if (s_we) begin
                for (int b = 0; b < 4; b++)
                    if (s_mask[b]) mem_arr[s_idx][b*8 +: 8] = s_wdata[b*8 +: 8];
            end else begin
                mem_rdata = mem_arr[s_idx];
            end
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic idle_all();
        set_cpu(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        set_dbg(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            mem_arr[i]   = 32'hA500_0000 + 32'(i);
            mem_model[i] = 32'hA500_0000 + 32'(i);
        end
        mem_arr[4]   = 32'hDEAD_BEEF;
        mem_model[4] = 32'hDEAD_BEEF;
        mem_rdata = 32'h0;
        model_reset();
        m_rdata = 32'h0;
        reset = 1'b1;
        idle_all();
        @(negedge clk);
        cycle();
        cycle();
        reset = 1'b0;

        // CPU-only read of 0x10
        set_cpu(1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
        cycle();
        idle_all();
        cycle();

        // Contention after reset: strict alternation starting with CPU
        reset = 1'b1; cycle(); reset = 1'b0;
        set_cpu(1'b1, 1'b0, 32'h14, 32'h0, 4'h0);
        set_dbg(1'b1, 1'b0, 32'h18, 32'h0, 4'h0, 1'b0);
        repeat (6) cycle();
        idle_all();
        cycle();

        // Debug write with partial mask, then read it back from the CPU
        set_dbg(1'b1, 1'b1, 32'h100, 32'h1234_5678, 4'b0011, 1'b0);
        cycle();
        idle_all();
        cycle();
        set_cpu(1'b1, 1'b0, 32'h100, 32'h0, 4'h0);
        cycle();
        idle_all();
        cycle();

        // Continuous lock with the CPU waiting
        reset = 1'b1; cycle(); reset = 1'b0;
        set_cpu(1'b1, 1'b0, 32'h20, 32'h0, 4'h0);
        set_dbg(1'b1, 1'b0, 32'h24, 32'h0, 4'h0, 1'b1);
        repeat (12) cycle();
        idle_all();
        cycle();

        // Early unlock after two locked cycles
        reset = 1'b1; cycle(); reset = 1'b0;
        set_dbg(1'b1, 1'b0, 32'h28, 32'h0, 4'h0, 1'b1);
        repeat (2) cycle();
        set_cpu(1'b1, 1'b0, 32'h2C, 32'h0, 4'h0);
        dbg_lock = 1'b0;
        repeat (3) cycle();
        idle_all();
        cycle();

        // Reset straight after a CPU read grant
        set_cpu(1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
        cycle();
        idle_all();
        reset = 1'b1; cycle(); reset = 1'b0;
        set_cpu(1'b1, 1'b0, 32'h30, 32'h0, 4'h0);
        set_dbg(1'b1, 1'b0, 32'h34, 32'h0, 4'h0, 1'b0);
        repeat (2) cycle();
        idle_all();
        cycle();

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            reset     = ($urandom_range(0, 49) == 0);
            cpu_req   = ($urandom_range(0, 3) != 0);
            cpu_we    = ($urandom_range(0, 2) == 0);
            cpu_addr  = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
            cpu_wdata = $urandom;
            cpu_wmask = 4'($urandom);
            dbg_req   = ($urandom_range(0, 2) != 0);
            dbg_we    = ($urandom_range(0, 2) == 0);
            dbg_addr  = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
            dbg_wdata = $urandom;
            dbg_wmask = 4'($urandom);
            dbg_lock  = ($urandom_range(0, 3) != 0);
            cycle();
        end
        reset = 1'b0;
        idle_all();
        cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter that shares the single-port unified instruction/data memory between the multicycle RV32I core and a debug/loader port. It sits in `top` between the core's memory interface and the memory instance, so a debug master can preload programs and inspect data memory while the core runs. Arbitration is round-robin, with an optional bounded lock for debug bursts. Read data is routed back to whichever requester issued the read.

## Interface
- ADDR_W, 32, byte address width
- DATA_W, 32, data width; the write mask is DATA_W/8 bits
- MAX_LOCK, 8, maximum consecutive cycles debug may hold the port under lock (≥1)

Ports:
- clk  in  1  system clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high
- cpu_req / dbg_req  in  1  access request; level, held until granted
- cpu_we / dbg_we  in  1  1 = write, 0 = read
- cpu_addr / dbg_addr  in  ADDR_W  byte address
- cpu_wdata / dbg_wdata  in  DATA_W  write data
- cpu_wmask / dbg_wmask  in  DATA_W/8  byte-lane write enables
- dbg_lock  in  1  keep ownership after the current debug grant
- cpu_gnt / dbg_gnt  out  1  combinational; access accepted this cycle
- cpu_rvalid / dbg_rvalid  out  1  registered; read data valid this cycle
- cpu_rdata / dbg_rdata  out  DATA_W  both driven from mem_rdata
- mem_en  out  1  memory access strobe
- mem_we  out  1  muxed write enable
- mem_addr  out  ADDR_W  muxed address
- mem_wdata  out  DATA_W  muxed write data
- mem_wmask  out  DATA_W/8  muxed write mask, qualified by mem_we
- mem_rdata  in  DATA_W  memory read data, valid one cycle after a read strobe

## Operation
- State registers:
  - last_gnt: CPU/DBG; reset = DBG, so the CPU wins the first tie.
  - locked: 1 bit; reset = 0.
  - lock_cnt: $clog2(MAX_LOCK+1) bits; reset = 0.
  - rd_pend: 1 bit; reset = 0.
  - rd_owner: CPU/DBG; reset = CPU.
- Grant decision, combinational, at most one grant per cycle:
  - reset = 1: no grant.
  - locked = 1 and lock_cnt < MAX_LOCK: only dbg can be granted. cpu_gnt = 0 even if cpu_req = 1.
  - Otherwise, only one requester: grant that requester.
  - Otherwise, both requesting: grant the requester that is not last_gnt.
- mem_en = cpu_gnt | dbg_gnt.
- mem_we/addr/wdata/wmask are taken from the granted requester. With no grant they hold the CPU's values and mem_en = 0.
- On each grant: last_gnt ← the granted requester.
- Lock FSM, states UNLOCKED and LOCKED:
  - UNLOCKED → LOCKED: on a dbg grant with dbg_lock = 1; lock_cnt ← 1.
  - In LOCKED, per cycle:
    - If lock_cnt == MAX_LOCK, force release: → UNLOCKED, lock_cnt ← 0, last_gnt ← DBG, so the CPU wins the next contention.
    - Else if dbg_lock = 0, → UNLOCKED, lock_cnt ← 0.
    - Else lock_cnt ← lock_cnt + 1 (saturates at MAX_LOCK).
    - Idle dbg cycles while locked still count.
- Read return:
  - A granted read sets rd_pend ← 1 and rd_owner ← the requester.
  - Any other cycle clears rd_pend ← 0.
  - x_rvalid = rd_pend & (rd_owner == x).
  - x_rdata = mem_rdata at all times; only rvalid qualifies it.
- Writes produce no response; the grant cycle completes the write.

## Timing
- Grant: 0-cycle latency. gnt is asserted in the same cycle as req when arbitration allows; the requester drops or changes req the next cycle.
- Read data: rvalid exactly 1 cycle after the read grant. Back-to-back reads give 1 access/cycle, and rvalid follows each grant by one cycle.
- Alternating contention: with both requesting every cycle and no lock, grants strictly alternate, starting with CPU after reset.
- Lock bound: under a continuous lock, debug holds at most MAX_LOCK consecutive grant cycles. The CPU is granted within MAX_LOCK+1 cycles of its request.
- Reset:
  - While reset = 1: all gnt, mem_en and rvalid are 0, and all state returns to its reset value on the edge.
  - A read granted in the cycle before reset asserts produces no rvalid.
- Simultaneous events:
  - dbg_lock rising in the same cycle as a CPU grant has no effect; lock only starts on a dbg grant.
  - Force-release and a new dbg_lock request in the same cycle: release wins.

## Test plan
- CPU only: read at 0x0000_0010 with the memory word = 0xDEAD_BEEF → cpu_gnt same cycle, mem_addr = 0x10, cpu_rvalid next cycle with cpu_rdata = 0xDEAD_BEEF, dbg_rvalid stays 0.
- Contention: both request reads every cycle for 6 cycles after reset → grants in the order CPU, DBG, CPU, DBG, CPU, DBG, and each rvalid lands on the matching requester one cycle later.
- Debug write: dbg write 0x1234_5678, mask 4'b0011, to 0x100 while the CPU is idle → mem_we = 1, mem_wmask = 4'b0011, no rvalid on either port.
- Lock starvation bound: MAX_LOCK = 4, dbg_req and dbg_lock held high, CPU requesting → exactly 4 consecutive dbg grants, then cpu_gnt, then normal alternation.
- Early unlock: lock for 2 cycles, then drop dbg_lock with the CPU requesting → cpu_gnt the next cycle and lock_cnt = 0.
- Reset mid-read: a CPU read is granted, then reset is asserted the next cycle → cpu_rvalid = 0. After release, the first tie goes to the CPU.
